// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: shifts a captured parallel pattern out LSB-first as the
// serial stimulus `w` for the Moore sequence detectors. Frames repeat with an
// optional idle gap between them. `z_exp` predicts the detector's `z`, which
// is high after two consecutive sampled 1s.
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int LENW  = 4,
    parameter int RPTW  = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LENW-1:0]  len,
    input  logic [RPTW-1:0]  reps,
    input  logic [1:0]       gap,
    output logic             ready,
    output logic             w,
    output logic             w_valid,
    output logic             last,
    output logic             done,
    output logic             z_exp
);

    // Wide enough to hold WIDTH itself (the effective length) and every bit index.
    localparam int IW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [IW-1:0]    len_q, len_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [RPTW-1:0]  frm_q, frm_d;
    logic [1:0]       gap_q, gap_d;
    logic [1:0]       gcnt_q, gcnt_d;
    logic             w_d;
    logic             last_d;
    logic             load;
    logic [WIDTH-1:0] shifted;
    logic [IW-1:0]    len_eff;
    logic             w_prev;

    // Effective frame length: 0 or anything above WIDTH selects WIDTH.
    always_comb begin
        if ((len == '0) || (32'(len) > 32'(WIDTH)))
            len_eff = IW'(WIDTH);
        else
            len_eff = IW'(len);
    end

    // Next-state and datapath update. `w` is registered, so each transition
    // loads the bit that will be visible in the following cycle.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        gap_d   = gap_q;
        frm_d   = frm_q;
        idx_d   = idx_q;
        gcnt_d  = gcnt_q;
        load    = 1'b0;
        shifted = '0;
        w_d     = 1'b0;
        last_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d   = pattern;
                    len_d   = len_eff;
                    frm_d   = reps;
                    gap_d   = gap;
                    idx_d   = '0;
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (idx_q == len_q - 1'b1) begin
                    if (frm_q == '0) begin
                        state_d = DONE;
                    end else begin
                        // frm_q counts the frames still to come after this one.
                        frm_d = frm_q - 1'b1;
                        if (gap_q != '0) begin
                            gcnt_d  = gap_q - 1'b1;
                            state_d = GAP;
                        end else begin
                            idx_d = '0;
                            load  = 1'b1;
                        end
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                    load  = 1'b1;
                end
            end
            GAP: begin
                if (gcnt_q == '0) begin
                    idx_d   = '0;
                    load    = 1'b1;
                    state_d = SHIFT;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            shifted = pat_d >> idx_d;
            w_d     = shifted[0];
            last_d  = (idx_d == len_d - 1'b1) && (frm_d == '0);
        end
    end

    // State, shadow registers and registered serial outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            frm_q   <= '0;
            idx_q   <= '0;
            gcnt_q  <= '0;
            w       <= 1'b0;
            last    <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            frm_q   <= frm_d;
            idx_q   <= idx_d;
            gcnt_q  <= gcnt_d;
            w       <= w_d;
            last    <= last_d;
        end
    end

    // Detector model: high when the last two sampled `w` values were both 1.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            w_prev <= 1'b0;
            z_exp  <= 1'b0;
        end else begin
            w_prev <= w;
            z_exp  <= w & w_prev;
        end
    end

    assign ready   = (state_q == IDLE);
    assign w_valid = (state_q == SHIFT);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed testbench for serial_pattern_tx. Each cycle after acceptance is
// captured as {w, w_valid, z_exp, last, done, ready} and compared against
// hand-derived per-cycle masks (bit n of each mask = cycle n).
module tb_serial_pattern_tx;

    logic       Clock;
    logic       Reset;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] reps;
    logic [1:0] gap;
    logic       ready;
    logic       w;
    logic       w_valid;
    logic       last;
    logic       done;
    logic       z_exp;

    int ncmp  = 0;
    int nfail = 0;

    logic [5:0] obs [0:31];

    serial_pattern_tx #(.WIDTH(8), .LENW(4), .RPTW(4)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .start   (start),
        .pattern (pattern),
        .len     (len),
        .reps    (reps),
        .gap     (gap),
        .ready   (ready),
        .w       (w),
        .w_valid (w_valid),
        .last    (last),
        .done    (done),
        .z_exp   (z_exp)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Waits (bounded) for ready, requests a transfer, then captures cycles
    // 1..ncyc. kind 1 pulses start (with changed inputs) in cycle dst;
    // kind 2 asserts Reset in cycle dst. hold keeps start high throughout.
    task automatic launch(input logic [7:0] p, input logic [3:0] l,
                          input logic [3:0] r, input logic [1:0] g,
                          input int ncyc, input int dst, input int kind,
                          input bit hold);
        int t;
        t = 0;
        while (!ready && t < 100) begin
            @(negedge Clock);
            t++;
        end
        ncmp++;
        if (ready !== 1'b1) begin
            nfail++;
            $display("FAIL ready_wait got %b want 1 after %0d cycles", ready, t);
        end
        for (int i = 0; i < 32; i++) obs[i] = '0;
        pattern = p;
        len     = l;
        reps    = r;
        gap     = g;
        start   = 1'b1;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge Clock);
            obs[n] = {w, w_valid, z_exp, last, done, ready};
            if (n == 1 && !hold) start = 1'b0;
            if (kind == 1 && n == dst) begin
                start   = 1'b1;
                pattern = 8'hFF;
                len     = 4'd8;
                reps    = 4'd3;
            end
            if (kind == 1 && n == dst + 1) start = 1'b0;
            if (kind == 2 && n == dst) Reset = 1'b1;
            if (kind == 2 && n == dst + 1) Reset = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        Reset   = 1'b1;
        start   = 1'b1;
        pattern = 8'hFF;
        len     = 4'd0;
        reps    = 4'd0;
        gap     = 2'd0;
        repeat (3) @(negedge Clock);
        got = {w, w_valid, z_exp, last, done, ready};
        ncmp++;
        if (got !== 6'b000001) begin
            nfail++;
            $display("FAIL reset_state {w,v,z,last,done,rdy} got %b want 000001", got);
        end
        Reset = 1'b0;
        start = 1'b0;
        @(negedge Clock);
        got = {w, w_valid, z_exp, last, done, ready};
        ncmp++;
        if (got !== 6'b000001) begin
            nfail++;
            $display("FAIL reset_release {w,v,z,last,done,rdy} got %b want 000001", got);
        end
    endtask

    task automatic test_basic();
        logic [31:0] ew, ev, ez, el, ed, er;
        logic [5:0]  e;
        launch(8'h06, 4'd4, 4'd0, 2'd0, 7, 0, 0, 1'b0);
        ew = 32'h0C; ev = 32'h1E; ez = 32'h10; el = 32'h10; ed = 32'h20; er = 32'hC0;
        for (int n = 1; n <= 7; n++) begin
            e = {ew[n], ev[n], ez[n], el[n], ed[n], er[n]};
            ncmp++;
            if (obs[n] !== e) begin
                nfail++;
                $display("FAIL basic cycle %0d {w,v,z,last,done,rdy} got %b want %b", n, obs[n], e);
            end
        end
    endtask

    task automatic test_full_width();
        logic [31:0] ew, ev, ez, el, ed, er;
        logic [5:0]  e;
        launch(8'hFF, 4'd0, 4'd0, 2'd0, 10, 0, 0, 1'b0);
        ew = 32'h1FE; ev = 32'h1FE; ez = 32'h3F8; el = 32'h100; ed = 32'h200; er = 32'h400;
        for (int n = 1; n <= 10; n++) begin
            e = {ew[n], ev[n], ez[n], el[n], ed[n], er[n]};
            ncmp++;
            if (obs[n] !== e) begin
                nfail++;
                $display("FAIL len0 cycle %0d {w,v,z,last,done,rdy} got %b want %b", n, obs[n], e);
            end
        end
    endtask

    task automatic test_frames_gap();
        logic [31:0] ew, ev, ez, el, ed, er;
        logic [5:0]  e;
        // Bit 3 of the pattern is 0 and must never be sent with len=3.
        launch(8'hF7, 4'd3, 4'd2, 2'd1, 13, 0, 0, 1'b0);
        ew = 32'hEEE; ev = 32'hEEE; ez = 32'h1998; el = 32'h800; ed = 32'h1000; er = 32'h2000;
        for (int n = 1; n <= 13; n++) begin
            e = {ew[n], ev[n], ez[n], el[n], ed[n], er[n]};
            ncmp++;
            if (obs[n] !== e) begin
                nfail++;
                $display("FAIL gap1 cycle %0d {w,v,z,last,done,rdy} got %b want %b", n, obs[n], e);
            end
        end
    endtask

    task automatic test_gap3();
        logic [31:0] ew, ev, ez, el, ed, er;
        logic [5:0]  e;
        launch(8'h01, 4'd1, 4'd1, 2'd3, 7, 0, 0, 1'b0);
        ew = 32'h22; ev = 32'h22; ez = 32'h0; el = 32'h20; ed = 32'h40; er = 32'h80;
        for (int n = 1; n <= 7; n++) begin
            e = {ew[n], ev[n], ez[n], el[n], ed[n], er[n]};
            ncmp++;
            if (obs[n] !== e) begin
                nfail++;
                $display("FAIL gap3 cycle %0d {w,v,z,last,done,rdy} got %b want %b", n, obs[n], e);
            end
        end
    endtask

    task automatic test_clamp();
        logic [31:0] ew, ev, ez, el, ed, er;
        logic [5:0]  e;
        launch(8'hA5, 4'd12, 4'd0, 2'd0, 10, 0, 0, 1'b0);
        ew = 32'h14A; ev = 32'h1FE; ez = 32'h0; el = 32'h100; ed = 32'h200; er = 32'h400;
        for (int n = 1; n <= 10; n++) begin
            e = {ew[n], ev[n], ez[n], el[n], ed[n], er[n]};
            ncmp++;
            if (obs[n] !== e) begin
                nfail++;
                $display("FAIL clamp cycle %0d {w,v,z,last,done,rdy} got %b want %b", n, obs[n], e);
            end
        end
    endtask

    task automatic test_busy_start();
        logic [31:0] ew, ev, ez, el, ed, er;
        logic [5:0]  e;
        launch(8'h06, 4'd4, 4'd0, 2'd0, 7, 3, 1, 1'b0);
        ew = 32'h0C; ev = 32'h1E; ez = 32'h10; el = 32'h10; ed = 32'h20; er = 32'hC0;
        for (int n = 1; n <= 7; n++) begin
            e = {ew[n], ev[n], ez[n], el[n], ed[n], er[n]};
            ncmp++;
            if (obs[n] !== e) begin
                nfail++;
                $display("FAIL busy_start cycle %0d {w,v,z,last,done,rdy} got %b want %b", n, obs[n], e);
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] ew, ev, ez, el, ed, er;
        logic [5:0]  e;
        launch(8'hFF, 4'd0, 4'd0, 2'd0, 9, 2, 2, 1'b0);
        ew = 32'h6; ev = 32'h6; ez = 32'h0; el = 32'h0; ed = 32'h0; er = 32'h3F8;
        for (int n = 1; n <= 9; n++) begin
            e = {ew[n], ev[n], ez[n], el[n], ed[n], er[n]};
            ncmp++;
            if (obs[n] !== e) begin
                nfail++;
                $display("FAIL abort cycle %0d {w,v,z,last,done,rdy} got %b want %b", n, obs[n], e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ew, ev, ez, el, ed, er;
        logic [5:0]  e;
        launch(8'h03, 4'd2, 4'd0, 2'd0, 8, 0, 0, 1'b1);
        ew = 32'h66; ev = 32'h66; ez = 32'h88; el = 32'h44; ed = 32'h88; er = 32'h110;
        for (int n = 1; n <= 8; n++) begin
            e = {ew[n], ev[n], ez[n], el[n], ed[n], er[n]};
            ncmp++;
            if (obs[n] !== e) begin
                nfail++;
                $display("FAIL back_to_back cycle %0d {w,v,z,last,done,rdy} got %b want %b", n, obs[n], e);
            end
        end
    endtask

    initial begin
        Reset   = 1'b1;
        start   = 1'b0;
        pattern = '0;
        len     = '0;
        reps    = '0;
        gap     = '0;
        test_reset();
        test_basic();
        test_full_width();
        test_frames_gap();
        test_gap3();
        test_clamp();
        test_busy_start();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
